// File: rtl/crt_bus_master.sv
// crt_bus_master: MCU-side initiator for the CRT 8-bit CPU bus (db/as/ds/wr).
// Turns single-cycle commands into timed address-strobe / data-strobe beats,
// mirrors the CRT address-byte selector and returns read bytes.
// Optional feature macro: CRT_BUS_BURST_EN (multi-beat WRITE/READ via cmd_len).
// Outputs are registered from the next-state decode, so the bus pins change
// exactly on the cycle the FSM enters each phase.
module crt_bus_master #(
  parameter int SETUP_W  = 1,
  parameter int STROBE_W = 4,
  parameter int HOLD_W   = 1,
  parameter int GAP_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  output logic [7:0]  db_o,
  output logic        db_oe,
  input  logic [7:0]  db_i,
  output logic        as,
  output logic        ds,
  output logic        wr,
  output logic [1:0]  sel_shadow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam logic [2:0] OP_ADDR      = 3'd0;
  localparam logic [2:0] OP_ADDR_PAGE = 3'd1;
  localparam logic [2:0] OP_WRITE     = 3'd2;
  localparam logic [2:0] OP_READ      = 3'd3;
  localparam logic [2:0] OP_POLL      = 3'd4;

  // Beat attributes {is_as, is_wr, byte} for a given command position.
  function automatic logic [9:0] beat_attr(input logic [2:0]  op,
                                           input logic        dummy,
                                           input logic [1:0]  beat,
                                           input logic [23:0] addr,
                                           input logic [7:0]  data);
    logic [9:0] v_attr;
    v_attr = 10'd0;
    case (op)
      OP_ADDR, OP_ADDR_PAGE: begin
        case (beat)
          2'd0:    v_attr = {1'b1, 1'b1, addr[7:0]};
          2'd1:    v_attr = {1'b1, 1'b1, addr[15:8]};
          2'd2:    v_attr = {1'b1, 1'b1, addr[23:16]};
          default: v_attr = {1'b1, 1'b1, data};
        endcase
      end
      OP_WRITE: v_attr = {1'b0, 1'b1, data};
      OP_READ:  v_attr = {1'b0, 1'b0, 8'h00};
      // The dummy read is a ds beat that only advances the CRT low address byte.
      OP_POLL:  v_attr = dummy ? {1'b0, 1'b0, 8'h00} : {1'b1, 1'b0, 8'h00};
      default:  v_attr = 10'd0;
    endcase
    return v_attr;
  endfunction

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_beat;
  logic [7:0]  r_last_idx;
  logic        r_dummy;
  logic [2:0]  r_op;
  logic [23:0] r_addr;
  logic [7:0]  r_data;

  logic [2:0]  w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_beat_nxt;
  logic [7:0]  w_last_idx_nxt;
  logic        w_dummy_nxt;
  logic [2:0]  w_op_nxt;
  logic [23:0] w_addr_nxt;
  logic [7:0]  w_data_nxt;

  logic        w_accept;
  logic        w_strobe_done;
  logic        w_cur_last;
  logic        w_capture;
  logic        w_active_nxt;
  logic [9:0]  w_cattr;
  logic [9:0]  w_nattr;
  logic [7:0]  w_len_idx;

`ifdef CRT_BUS_BURST_EN
  assign w_len_idx = cmd_len;
`else
  logic w_unused_len;
  assign w_unused_len = ^cmd_len;
  assign w_len_idx    = 8'd0;
`endif

  assign cmd_ready     = (r_state == S_IDLE) & ~reset;
  assign w_accept      = cmd_valid & cmd_ready;
  assign w_strobe_done = (r_state == S_STROBE) && (r_cnt == 8'(STROBE_W - 1));
  assign w_cur_last    = ~r_dummy && (r_beat == r_last_idx);
  assign w_cattr       = beat_attr(r_op, r_dummy, r_beat[1:0], r_addr, r_data);
  assign w_nattr       = beat_attr(w_op_nxt, w_dummy_nxt, w_beat_nxt[1:0], w_addr_nxt, w_data_nxt);
  assign w_capture     = w_strobe_done && ~w_cattr[8];
  assign w_active_nxt  = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                         (w_state_nxt == S_HOLD);

  // Next-state decode: phase sequencing, beat stepping and operand latching.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_beat_nxt     = r_beat;
    w_last_idx_nxt = r_last_idx;
    w_dummy_nxt    = r_dummy;
    w_op_nxt       = r_op;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nxt    = cmd_op;
          w_addr_nxt  = cmd_addr;
          w_data_nxt  = cmd_data;
          w_beat_nxt  = 8'd0;
          w_cnt_nxt   = 8'd0;
          w_dummy_nxt = (cmd_op == OP_POLL) && (sel_shadow != 2'd0);
          case (cmd_op)
            OP_ADDR:           w_last_idx_nxt = 8'd2;
            OP_ADDR_PAGE:      w_last_idx_nxt = 8'd3;
            OP_WRITE, OP_READ: w_last_idx_nxt = w_len_idx;
            OP_POLL:           w_last_idx_nxt = 8'd3;
            default:           w_last_idx_nxt = 8'd0;
          endcase
          // Reserved ops are swallowed: no beats, stay idle.
          if (cmd_op <= OP_POLL) begin
            w_state_nxt = S_SETUP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (r_cnt == 8'(SETUP_W - 1)) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_STROBE: begin
        if (w_strobe_done) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == 8'(HOLD_W - 1)) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == 8'(GAP_W - 1)) begin
          w_cnt_nxt = 8'd0;
          if (w_cur_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_SETUP;
            if (r_dummy) begin
              w_dummy_nxt = 1'b0;
            end else begin
              w_beat_nxt = r_beat + 8'd1;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // FSM and latched-command state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_beat     <= 8'd0;
      r_last_idx <= 8'd0;
      r_dummy    <= 1'b0;
      r_op       <= 3'd0;
      r_addr     <= 24'd0;
      r_data     <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_beat     <= w_beat_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_dummy    <= w_dummy_nxt;
      r_op       <= w_op_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
    end
  end

  // Bus pins: wr/db held from SETUP through HOLD, strobe only in STROBE.
  always_ff @(posedge clk) begin
    if (reset) begin
      as    <= 1'b0;
      ds    <= 1'b0;
      wr    <= 1'b0;
      db_oe <= 1'b0;
      db_o  <= 8'h00;
    end else begin
      as    <= (w_state_nxt == S_STROBE) & w_nattr[9];
      ds    <= (w_state_nxt == S_STROBE) & ~w_nattr[9];
      wr    <= w_active_nxt & w_nattr[8];
      db_oe <= w_active_nxt & w_nattr[8];
      db_o  <= (w_active_nxt & w_nattr[8]) ? w_nattr[7:0] : 8'h00;
    end
  end

  // Selector mirror: +1 on every as fall, cleared on every ds rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_shadow <= 2'd0;
    end else if (w_strobe_done && w_cattr[9]) begin
      sel_shadow <= sel_shadow + 2'd1;
    end else if ((r_state != S_STROBE) && (w_state_nxt == S_STROBE) && ~w_nattr[9]) begin
      sel_shadow <= 2'd0;
    end else begin
      sel_shadow <= sel_shadow;
    end
  end

  // Read response: capture db_i in the last STROBE cycle, pulse in first HOLD cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      rsp_valid <= w_capture & ~r_dummy;
      rsp_last  <= w_capture & w_cur_last;
      if (w_capture) begin
        rsp_data <= db_i;
      end else begin
        rsp_data <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_crt_bus_master.sv
// Directed self-checking bench for crt_bus_master.
module tb_crt_bus_master;

  typedef struct packed {
    logic       is_as;
    logic       wr;
    logic       oe;
    logic [7:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [7:0]  cmd_len;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic [7:0]  db_o;
  logic        db_oe;
  logic [7:0]  db_i = 8'h00;
  logic        as;
  logic        ds;
  logic        wr;
  logic [1:0]  sel_shadow;

  int checks = 0;
  int failures = 0;

  beat_t      beat_q[$];
  logic [8:0] rsp_q[$];
  logic [7:0] rd_q[$];
  int         oe_cnt = 0;
  int         both_cnt = 0;
  logic       prev_as = 1'b0;
  logic       prev_ds = 1'b0;

  crt_bus_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .db_o(db_o), .db_oe(db_oe), .db_i(db_i),
    .as(as), .ds(ds), .wr(wr), .sel_shadow(sel_shadow)
  );

  always #5 clk = ~clk;

  // Bus model and monitor: log strobe beats and responses, serve read bytes.
  always @(negedge clk) begin
    if ((as && !prev_as) || (ds && !prev_ds)) begin
      beat_q.push_back({as, wr, db_oe, db_o});
      if (!wr) begin
        db_i <= (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
      end
    end
    if (db_oe) oe_cnt <= oe_cnt + 1;
    if (as && ds) both_cnt <= both_cnt + 1;
    if (rsp_valid) rsp_q.push_back({rsp_last, rsp_data});
    prev_as <= as;
    prev_ds <= ds;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [23:0] addr,
                      input logic [7:0] data, input logic [7:0] len);
    int t;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_len = len;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 32'(t < 100), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
  endtask

  task automatic clr();
    beat_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    int n;
    int oe0;
    int both0;
    logic [7:0] exp_b[5];

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
    cmd_addr = 24'd0; cmd_data = 8'd0; cmd_len = 8'd0;
    both0 = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_strobes", {28'd0, as, ds, wr, db_oe}, 32'd0);
    chk("rst_db_o", 32'(db_o), 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_last}, 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_sel", 32'(sel_shadow), 32'd0);
    chk("rst_ready_low", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // 1: ADDR_PAGE -> 4 as-writes, 36 busy cycles, selector wraps back to 0
    clr();
    send(3'd1, 24'h213456, 8'h05, 8'd0);
    wait_idle(n);
    chk("t1_cycles", 32'(n), 32'd37);
    chk("t1_beats", 32'(beat_q.size()), 32'd4);
    exp_b[0] = 8'h56; exp_b[1] = 8'h34; exp_b[2] = 8'h21; exp_b[3] = 8'h05;
    for (int i = 0; i < 4; i++) begin
      if (i < beat_q.size()) begin
        chk("t1_beat", 32'(beat_q[i]), 32'({1'b1, 1'b1, 1'b1, exp_b[i]}));
      end
    end
    chk("t1_sel", 32'(sel_shadow), 32'd0);

    // 2: ADDR then WRITE
    clr();
    send(3'd0, 24'h000010, 8'h00, 8'd0);
    wait_idle(n);
    chk("t2_addr_beats", 32'(beat_q.size()), 32'd3);
    if (beat_q.size() > 0) chk("t2_addr_lo", 32'(beat_q[0]), 32'({3'b111, 8'h10}));
    chk("t2_sel3", 32'(sel_shadow), 32'd3);
    clr();
    send(3'd2, 24'h000000, 8'hA5, 8'd0);
    wait_idle(n);
    chk("t2_wr_cycles", 32'(n), 32'd10);
    chk("t2_wr_beats", 32'(beat_q.size()), 32'd1);
    if (beat_q.size() > 0) chk("t2_wr_beat", 32'(beat_q[0]), 32'({3'b011, 8'hA5}));
    chk("t2_sel0", 32'(sel_shadow), 32'd0);

    // 3: single READ, db_oe never asserted
    clr();
    rd_q.delete();
    rd_q.push_back(8'h3C);
    oe0 = oe_cnt;
    send(3'd3, 24'h000000, 8'h00, 8'd0);
    wait_idle(n);
    chk("t3_oe_never", 32'(oe_cnt - oe0), 32'd0);
    chk("t3_beats", 32'(beat_q.size()), 32'd1);
    if (beat_q.size() > 0) chk("t3_beat", 32'(beat_q[0]), 32'd0);
    chk("t3_rsp_cnt", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) chk("t3_rsp", 32'(rsp_q[0]), 32'({1'b1, 8'h3C}));

    // 4: POLL with selector=3 -> dummy ds-read then 4 as-reads
    send(3'd0, 24'h000000, 8'h00, 8'd0);
    wait_idle(n);
    chk("t4_sel3", 32'(sel_shadow), 32'd3);
    clr();
    rd_q.delete();
    rd_q.push_back(8'hEE); rd_q.push_back(8'h12); rd_q.push_back(8'h34);
    rd_q.push_back(8'h80); rd_q.push_back(8'h7F);
    send(3'd4, 24'h000000, 8'h00, 8'd0);
    wait_idle(n);
    chk("t4_cycles", 32'(n), 32'd46);
    chk("t4_beats", 32'(beat_q.size()), 32'd5);
    if (beat_q.size() == 5) begin
      chk("t4_dummy_ds", 32'(beat_q[0].is_as), 32'd0);
      for (int i = 1; i < 5; i++) chk("t4_as_read", 32'({beat_q[i].is_as, beat_q[i].wr}), 32'd2);
    end
    exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h80; exp_b[3] = 8'h7F;
    chk("t4_rsp_cnt", 32'(rsp_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_q.size()) chk("t4_rsp", 32'(rsp_q[i]), 32'({(i == 3), exp_b[i]}));
    end
    chk("t4_sel0", 32'(sel_shadow), 32'd0);

    // POLL with selector already 0 -> no dummy beat
    clr();
    rd_q.delete();
    rd_q.push_back(8'h01); rd_q.push_back(8'h02); rd_q.push_back(8'h03); rd_q.push_back(8'h04);
    send(3'd4, 24'h000000, 8'h00, 8'd0);
    wait_idle(n);
    chk("t4b_beats", 32'(beat_q.size()), 32'd4);
    chk("t4b_rsp_cnt", 32'(rsp_q.size()), 32'd4);
    if (rsp_q.size() == 4) chk("t4b_last", 32'(rsp_q[3]), 32'({1'b1, 8'h04}));

    // Reserved op: accepted, no beats, idle next cycle
    clr();
    send(3'd6, 24'h123456, 8'h11, 8'd0);
    wait_idle(n);
    chk("rsv_cycles", 32'(n), 32'd1);
    chk("rsv_beats", 32'(beat_q.size() + rsp_q.size()), 32'd0);

    // 5: reset in 2nd STROBE cycle of a WRITE
    send(3'd2, 24'h000000, 8'h77, 8'd0);
    repeat (3) @(negedge clk);
    chk("t5_ds_mid", 32'(ds), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_strobes", {28'd0, as, ds, wr, db_oe}, 32'd0);
    chk("t5_sel", 32'(sel_shadow), 32'd0);
    chk("t5_ready_low", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_ready", 32'(cmd_ready), 32'd1);

    // 6: READ with cmd_len=3
    clr();
    rd_q.delete();
    rd_q.push_back(8'hA1); rd_q.push_back(8'hA2); rd_q.push_back(8'hA3); rd_q.push_back(8'hA4);
    send(3'd3, 24'h000000, 8'h00, 8'd3);
    wait_idle(n);
`ifdef CRT_BUS_BURST_EN
    chk("t6_cycles", 32'(n), 32'd37);
    chk("t6_rsp_cnt", 32'(rsp_q.size()), 32'd4);
    exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3; exp_b[3] = 8'hA4;
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_q.size()) chk("t6_rsp", 32'(rsp_q[i]), 32'({(i == 3), exp_b[i]}));
    end
`else
    chk("t6_cycles", 32'(n), 32'd10);
    chk("t6_rsp_cnt", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) chk("t6_rsp", 32'(rsp_q[0]), 32'({1'b1, 8'hA1}));
`endif
    chk("never_as_and_ds", 32'(both_cnt), 32'(both0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
